// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg
// Default 640x480@60 timing constants, colour type and bar-colour helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef logic [11:0] rgb12_t;

    function automatic rgb12_t bar_colour(input logic [2:0] idx);
        return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
// ============================================================================
// vga_delay_line
// WIDTH x DEPTH shift register, async active-low clear to RST_VAL; DEPTH=0 passes through.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_ctrl;
            assign w_unused_ctrl = clk ^ rst;
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
                end else begin
                    r_stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_scan_ctrl.sv
// ============================================================================
// vga_scan_ctrl
// VGA scan counters, coordinate publish, latency-matched blanking and sync.
// Build option VGA_SCAN_TESTPAT_EN: replace Din by an 8-bar colour pattern.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int LATENCY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] Din,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        EN,
    output logic        frame_start,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 11-bit compare constants so a total of exactly 1024 stays representable
    localparam logic [10:0] c_h_last  = 11'(H_TOTAL - 1);
    localparam logic [10:0] c_v_last  = 11'(V_TOTAL - 1);
    localparam logic [10:0] c_h_act   = 11'(H_ACTIVE);
    localparam logic [10:0] c_v_act   = 11'(V_ACTIVE);
    localparam logic [10:0] c_hs_beg  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_hs_end  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_vs_beg  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_vs_end  = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [10:0] w_h;
    logic [10:0] w_v;
    logic        w_act;
    logic        w_hs_n;
    logic        w_vs_n;
    logic [2:0]  w_flag_dly;
    rgb12_t      w_colour;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if ({1'b0, r_h_cnt} == c_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= ({1'b0, r_v_cnt} == c_v_last) ? '0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    assign w_h    = {1'b0, r_h_cnt};
    assign w_v    = {1'b0, r_v_cnt};
    assign w_act  = (w_h < c_h_act) && (w_v < c_v_act);
    assign w_hs_n = !((w_h >= c_hs_beg) && (w_h < c_hs_end));
    assign w_vs_n = !((w_v >= c_vs_beg) && (w_v < c_vs_end));

    assign x           = r_h_cnt;
    assign y           = r_v_cnt;
    assign EN          = w_act;
    assign frame_start = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

    // Flags travel alongside the compositor pipeline so they line up with Din
    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (LATENCY),
        .RST_VAL (3'b011)
    ) u_flag_dly (
        .clk (clk),
        .rst (rst),
        .d   ({w_act, w_hs_n, w_vs_n}),
        .q   (w_flag_dly)
    );

`ifdef VGA_SCAN_TESTPAT_EN
    logic [2:0] w_bar_idx;
    logic       w_unused_din;

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (LATENCY),
        .RST_VAL (3'b000)
    ) u_bar_dly (
        .clk (clk),
        .rst (rst),
        .d   (r_h_cnt[9:7]),
        .q   (w_bar_idx)
    );

    assign w_unused_din = ^Din;
    assign w_colour     = bar_colour(w_bar_idx);
`else
    assign w_colour = Din;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb   <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            rgb   <= w_flag_dly[2] ? w_colour : 12'h000;
            hsync <= w_flag_dly[1];
            vsync <= w_flag_dly[0];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
// ============================================================================
// tb_vga_scan_ctrl
// Random-Din bench for vga_scan_ctrl with a short-frame vertical timing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_scan_ctrl;

    localparam int HA = 640, HFP = 16, HS = 96, HBP = 48;
    localparam int VA = 6,   VFP = 2,  VS = 2,  VBP = 2;
    localparam int LAT   = 2;
    localparam int HT    = HA + HFP + HS + HBP;
    localparam int VT    = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] Din = '0;
    logic [9:0]  x, y;
    logic        EN, frame_start, hsync, vsync;
    logic [11:0] rgb;

    int n_vec = 0;
    int n_err = 0;
    int n     = 0;
    logic [11:0] din_ring [4];

    bit agg_on = 0;
    int fs_cnt = 0, hs_low = 0, vs_low = 0;

    vga_scan_ctrl #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .LATENCY  (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Din         (Din),
        .x           (x),
        .y           (y),
        .EN          (EN),
        .frame_start (frame_start),
        .rgb         (rgb),
        .hsync       (hsync),
        .vsync       (vsync)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, n, $time);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_en", 32'(EN), 1);
        check("rst_fs", 32'(frame_start), 1);
        check("rst_rgb", 32'(rgb), 0);
        check("rst_hsync", 32'(hsync), 1);
        check("rst_vsync", 32'(vsync), 1);
    endtask

    task automatic drive_din();
        din_ring[n % 4] = 12'($urandom);
        Din = din_ring[n % 4];
    endtask

    // Reference: after n edges the counters show pixel n mod FRAME, and the
    // outputs describe the pixel shown LAT+1 cycles earlier.
    function automatic logic [11:0] pixel_colour(input int qh, input logic [11:0] din);
`ifdef VGA_SCAN_TESTPAT_EN
        int idx = qh / 128;
        return ((idx & 4) != 0 ? 12'hF00 : 12'h000) |
               ((idx & 2) != 0 ? 12'h0F0 : 12'h000) |
               ((idx & 1) != 0 ? 12'h00F : 12'h000);
`else
        return din;
`endif
    endfunction

    task automatic check_all();
        int p  = n % FRAME;
        int ex = p % HT;
        int ey = p / HT;
        logic [11:0] er;
        logic ehs, evs;
        if (n < LAT + 1) begin
            er = 0; ehs = 1; evs = 1;
        end else begin
            int q  = (n - LAT - 1) % FRAME;
            int qh = q % HT;
            int qv = q / HT;
            er  = (qh < HA && qv < VA) ? pixel_colour(qh, din_ring[(n - 1) % 4]) : 12'h000;
            ehs = !(qh >= HA + HFP && qh < HA + HFP + HS);
            evs = !(qv >= VA + VFP && qv < VA + VFP + VS);
        end
        check("x", 32'(x), 32'(ex));
        check("y", 32'(y), 32'(ey));
        check("en", 32'(EN), 32'(ex < HA && ey < VA));
        check("frame_start", 32'(frame_start), 32'(p == 0));
        check("rgb", 32'(rgb), 32'(er));
        check("hsync", 32'(hsync), 32'(ehs));
        check("vsync", 32'(vsync), 32'(evs));
    endtask

    task automatic run_cycles(input int cnt);
        repeat (cnt) begin
            @(posedge clk);
            n++;
            #1 drive_din();
            @(negedge clk);
            check_all();
            if (agg_on) begin
                fs_cnt += int'(frame_start);
                hs_low += int'(!hsync);
                vs_low += int'(!vsync);
            end
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        n   = 0;
        drive_din();
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            Din = 12'($urandom);
            check_reset_vals();
        end
        release_reset();

        agg_on = 1;
        run_cycles(FRAME);
        agg_on = 0;
        check("frame_start_per_frame", 32'(fs_cnt), 1);
        check("hsync_low_per_frame", 32'(hs_low), 32'(HS * VT));
        check("vsync_low_per_frame", 32'(vs_low), 32'(VS * HT));

        // Abort mid-frame inside an hsync pulse; nothing may be stretched
        run_cycles(3 * HT + 700);
        #2 rst = 1'b0;
        #1 check_reset_vals();
        release_reset();

        run_cycles(FRAME + 1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
